seller_arb: RTL and testbench

Arbiter and transaction sequencer that shares one vending core (`seller1`-style coin FSM: coin strobes `d1`/`d2`/`d3`, vend `out1`, change `out2`) between two customer panels A and B. It grants the core to one panel at a time, forwards that panel's coin strobes, and tracks the credit the panel has inserted. It ends each session on a vend, a cancel or an inactivity timeout. On cancel or timeout it flushes the core and reports the credit to refund. It sits between the panel I/O logic and the core, and owns the core's reset.

---
 rtl/seller_arb.sv | 207 ++++++++++++++++++++
 tb/tb_seller_arb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seller_arb.sv
// seller_arb: grants one shared vending core to panel A or B, forwards the owner's
// coins, tracks its credit, and ends the session on vend, cancel or inactivity timeout.
module seller_arb #(
   parameter int TIMEOUT  = 200,
   parameter int CREDIT_W = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                a_req_i,
   input  logic                b_req_i,
   input  logic [2:0]          a_coin_i,
   input  logic [2:0]          b_coin_i,
   input  logic                a_cancel_i,
   input  logic                b_cancel_i,
   output logic                a_grant_o,
   output logic                b_grant_o,
   output logic                core_d1_o,
   output logic                core_d2_o,
   output logic                core_d3_o,
   output logic                core_rst_o,
   input  logic                core_out1_i,
   input  logic [1:0]          core_out2_i,
   output logic                vend_a_o,
   output logic                vend_b_o,
   output logic [1:0]          change_o,
   output logic                refund_valid_o,
   output logic [CREDIT_W-1:0] refund_units_o,
   output logic                busy_o
);

   localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SERVE = 2'd1, ST_ABORT = 2'd2} state_t;

   function automatic logic is_onehot3(input logic [2:0] c);
      return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
   endfunction

   function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] c);
      case (c)
         3'b100:  return CREDIT_W'(1);
         3'b010:  return CREDIT_W'(2);
         3'b001:  return CREDIT_W'(4);
         default: return '0;
      endcase
   endfunction

   function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[CREDIT_W]) begin
         return '1;
      end else begin
         return s[CREDIT_W-1:0];
      end
   endfunction

   state_t               state_q;
   logic                 owner_q;   // 0 = A, 1 = B
   logic                 last_q;
   logic [CREDIT_W-1:0]  credit_q;
   logic [TIMER_W-1:0]   timer_q;
   logic                 a_grant_q, b_grant_q;
   logic                 d1_q, d2_q, d3_q;
   logic                 vend_a_q, vend_b_q;
   logic [1:0]           change_q;
   logic                 refund_valid_q;
   logic [CREDIT_W-1:0]  refund_units_q;
   logic                 busy_q;

   logic [2:0]           coin_s;
   logic                 cancel_s;
   logic                 coin_ok_s;
   logic [CREDIT_W-1:0]  credit_d;

   // Select the owner's coin/cancel and compute the credit after this cycle's coin.
   always_comb begin
      coin_s    = 3'b000;
      cancel_s  = 1'b0;
      if (owner_q) begin
         coin_s   = b_coin_i;
         cancel_s = b_cancel_i;
      end else begin
         coin_s   = a_coin_i;
         cancel_s = a_cancel_i;
      end
      coin_ok_s = is_onehot3(coin_s);
      if (coin_ok_s) begin
         credit_d = sat_add(credit_q, coin_value(coin_s));
      end else begin
         credit_d = credit_q;
      end
   end

   // Session FSM with all registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q        <= ST_IDLE;
         owner_q        <= 1'b0;
         last_q         <= 1'b1;
         credit_q       <= '0;
         timer_q        <= '0;
         a_grant_q      <= 1'b0;
         b_grant_q      <= 1'b0;
         d1_q           <= 1'b0;
         d2_q           <= 1'b0;
         d3_q           <= 1'b0;
         vend_a_q       <= 1'b0;
         vend_b_q       <= 1'b0;
         change_q       <= 2'b00;
         refund_valid_q <= 1'b0;
         refund_units_q <= '0;
         busy_q         <= 1'b0;
      end else begin
         d1_q           <= 1'b0;
         d2_q           <= 1'b0;
         d3_q           <= 1'b0;
         vend_a_q       <= 1'b0;
         vend_b_q       <= 1'b0;
         refund_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               credit_q <= '0;
               timer_q  <= '0;
               // Tie goes to the panel that was not served last.
               if (a_req_i && (!b_req_i || last_q)) begin
                  owner_q   <= 1'b0;
                  a_grant_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SERVE;
               end else if (b_req_i) begin
                  owner_q   <= 1'b1;
                  b_grant_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SERVE;
               end else begin
                  state_q   <= ST_IDLE;
               end
            end
            ST_SERVE: begin
               if (core_out1_i) begin
                  vend_a_q  <= ~owner_q;
                  vend_b_q  <= owner_q;
                  change_q  <= core_out2_i;
                  credit_q  <= '0;
                  last_q    <= owner_q;
                  a_grant_q <= 1'b0;
                  b_grant_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (cancel_s) begin
                  credit_q       <= credit_d;
                  refund_units_q <= credit_d;
                  refund_valid_q <= 1'b1;
                  a_grant_q      <= 1'b0;
                  b_grant_q      <= 1'b0;
                  state_q        <= ST_ABORT;
               end else if (coin_ok_s) begin
                  credit_q <= credit_d;
                  timer_q  <= '0;
                  d1_q     <= coin_s[2];
                  d2_q     <= coin_s[1];
                  d3_q     <= coin_s[0];
               end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                  refund_units_q <= credit_q;
                  refund_valid_q <= 1'b1;
                  a_grant_q      <= 1'b0;
                  b_grant_q      <= 1'b0;
                  state_q        <= ST_ABORT;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            ST_ABORT: begin
               last_q   <= owner_q;
               credit_q <= '0;
               timer_q  <= '0;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               a_grant_q <= 1'b0;
               b_grant_q <= 1'b0;
               credit_q  <= '0;
               timer_q   <= '0;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign core_rst_o     = rst_i & (state_q != ST_ABORT);
   assign a_grant_o      = a_grant_q;
   assign b_grant_o      = b_grant_q;
   assign core_d1_o      = d1_q;
   assign core_d2_o      = d2_q;
   assign core_d3_o      = d3_q;
   assign vend_a_o       = vend_a_q;
   assign vend_b_o       = vend_b_q;
   assign change_o       = change_q;
   assign refund_valid_o = refund_valid_q;
   assign refund_units_o = refund_units_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_seller_arb.sv
// Directed bench for seller_arb with TIMEOUT=8; expected values are hand-computed.
module tb_seller_arb;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       a_req_i = 1'b0, b_req_i = 1'b0;
   logic [2:0] a_coin_i = 3'b000, b_coin_i = 3'b000;
   logic       a_cancel_i = 1'b0, b_cancel_i = 1'b0;
   logic       core_out1_i = 1'b0;
   logic [1:0] core_out2_i = 2'b00;
   logic       a_grant_o, b_grant_o, core_d1_o, core_d2_o, core_d3_o, core_rst_o;
   logic       vend_a_o, vend_b_o, refund_valid_o, busy_o;
   logic [1:0] change_o;
   logic [3:0] refund_units_o;

   int n_checks = 0;
   int n_fail   = 0;

   seller_arb #(.TIMEOUT(8), .CREDIT_W(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .a_req_i(a_req_i), .b_req_i(b_req_i),
      .a_coin_i(a_coin_i), .b_coin_i(b_coin_i),
      .a_cancel_i(a_cancel_i), .b_cancel_i(b_cancel_i),
      .a_grant_o(a_grant_o), .b_grant_o(b_grant_o),
      .core_d1_o(core_d1_o), .core_d2_o(core_d2_o), .core_d3_o(core_d3_o),
      .core_rst_o(core_rst_o),
      .core_out1_i(core_out1_i), .core_out2_i(core_out2_i),
      .vend_a_o(vend_a_o), .vend_b_o(vend_b_o), .change_o(change_o),
      .refund_valid_o(refund_valid_o), .refund_units_o(refund_units_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   logic [15:0] all_outs;
   logic [2:0]  strobes;
   assign all_outs = {a_grant_o, b_grant_o, core_d1_o, core_d2_o, core_d3_o, core_rst_o,
                      vend_a_o, vend_b_o, change_o, refund_valid_o, refund_units_o, busy_o};
   assign strobes  = {core_d1_o, core_d2_o, core_d3_o};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held 3 cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_outs", 32'(all_outs), 32'h0);
      end

      // Release with a tie: A wins.
      rst_i = 1'b1; a_req_i = 1'b1; b_req_i = 1'b1;
      tick();
      chk("tie_a_grant", 32'(a_grant_o), 32'd1);
      chk("tie_b_grant", 32'(b_grant_o), 32'd0);
      chk("busy_serve",  32'(busy_o),    32'd1);
      chk("core_rst_hi", 32'(core_rst_o), 32'd1);

      // Vend path for A: coins 100,010,100,100.
      a_coin_i = 3'b100; tick(); chk("coin1_d1", 32'(strobes), 32'b100);
      a_coin_i = 3'b010; tick(); chk("coin2_d2", 32'(strobes), 32'b010);
      a_coin_i = 3'b100; tick(); chk("coin3_d1", 32'(strobes), 32'b100);
      a_coin_i = 3'b100; tick(); chk("coin4_d1", 32'(strobes), 32'b100);
      a_coin_i = 3'b000; tick(); chk("pulse_end", 32'(strobes), 32'b000);
      b_coin_i = 3'b001; tick(); chk("b_coin_dropped", 32'(strobes), 32'b000);
      b_coin_i = 3'b000; a_coin_i = 3'b110; tick(); chk("coin110_ignored", 32'(strobes), 32'b000);
      a_coin_i = 3'b000;
      // Vend together with a cancel: vend only.
      core_out1_i = 1'b1; core_out2_i = 2'b01; a_cancel_i = 1'b1;
      tick();
      chk("vend_a",      32'(vend_a_o), 32'd1);
      chk("vend_b_idle", 32'(vend_b_o), 32'd0);
      chk("change",      32'(change_o), 32'b01);
      chk("vend_no_refund", 32'(refund_valid_o), 32'd0);
      chk("grant_drop",  32'(a_grant_o), 32'd0);
      chk("busy_fall",   32'(busy_o),   32'd0);
      core_out1_i = 1'b0; core_out2_i = 2'b00; a_cancel_i = 1'b0;
      tick();
      chk("rr_b_grant",  32'(b_grant_o), 32'd1);
      chk("rr_a_grant",  32'(a_grant_o), 32'd0);
      chk("vend_pulse_end", 32'(vend_a_o), 32'd0);
      chk("no_refund_after_vend", 32'(refund_valid_o), 32'd0);

      // Cancel for B with credit 6.
      a_req_i = 1'b0; b_req_i = 1'b0;
      b_coin_i = 3'b001; tick(); chk("b_coin_d3", 32'(strobes), 32'b001);
      b_coin_i = 3'b010; tick(); chk("b_coin_d2", 32'(strobes), 32'b010);
      b_coin_i = 3'b000; b_cancel_i = 1'b1;
      tick();
      chk("cancel_refund_valid", 32'(refund_valid_o), 32'd1);
      chk("cancel_refund_units", 32'(refund_units_o), 32'd6);
      chk("cancel_core_rst",     32'(core_rst_o), 32'd0);
      chk("cancel_busy",         32'(busy_o), 32'd1);
      b_cancel_i = 1'b0;
      tick();
      chk("after_abort_valid", 32'(refund_valid_o), 32'd0);
      chk("after_abort_rst",   32'(core_rst_o), 32'd1);
      chk("after_abort_busy",  32'(busy_o), 32'd0);

      // Timeout: grant A, coin 010, then idle.
      a_req_i = 1'b1; tick(); chk("to_grant", 32'(a_grant_o), 32'd1);
      a_req_i = 1'b0; a_coin_i = 3'b010; tick(); chk("to_coin", 32'(strobes), 32'b010);
      a_coin_i = 3'b000;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("to_early", 32'(refund_valid_o), 32'd0);
      end
      tick();
      chk("to_refund_valid", 32'(refund_valid_o), 32'd1);
      chk("to_refund_units", 32'(refund_units_o), 32'd2);
      tick();

      // Cancel with a coin in the same cycle, credit 2.
      b_req_i = 1'b1; tick(); chk("cc_grant", 32'(b_grant_o), 32'd1);
      b_req_i = 1'b0; b_coin_i = 3'b010; tick();
      b_coin_i = 3'b001; b_cancel_i = 1'b1; tick();
      chk("cc_no_d3",        32'(strobes), 32'b000);
      chk("cc_refund_valid", 32'(refund_valid_o), 32'd1);
      chk("cc_refund_units", 32'(refund_units_o), 32'd6);
      b_coin_i = 3'b000; b_cancel_i = 1'b0; tick();

      // Saturation: four 4-unit coins clamp at 15.
      a_req_i = 1'b1; tick(); a_req_i = 1'b0;
      a_coin_i = 3'b001;
      for (int i = 0; i < 4; i++) tick();
      a_coin_i = 3'b000; a_cancel_i = 1'b1; tick();
      chk("sat_refund_units", 32'(refund_units_o), 32'd15);
      a_cancel_i = 1'b0; tick();

      // Reset mid-session with credit 4.
      a_req_i = 1'b1; tick(); a_req_i = 1'b0;
      a_coin_i = 3'b001; tick(); a_coin_i = 3'b000;
      rst_i = 1'b0; tick();
      chk("mid_reset_outs",     32'(all_outs), 32'h0);
      chk("mid_reset_core_rst", 32'(core_rst_o), 32'd0);
      rst_i = 1'b1; tick();
      chk("mid_reset_no_refund", 32'(refund_valid_o), 32'd0);
      chk("mid_reset_idle",      32'(busy_o), 32'd0);
      // Credit cleared: zero-credit cancel still reports a refund of 0.
      a_req_i = 1'b1; tick(); a_req_i = 1'b0;
      a_cancel_i = 1'b1; tick(); a_cancel_i = 1'b0;
      chk("zero_refund_valid", 32'(refund_valid_o), 32'd1);
      chk("zero_refund_units", 32'(refund_units_o), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
